// File: rtl/matvec_mul_stream.sv
// matvec_mul_stream: pipelined R x C matrix-vector multiply with packet accumulation and valid/ready flow control.
module matvec_mul_stream #(
  parameter int R = 2,
  parameter int C = 5,
  parameter int W_X = 3,
  parameter int W_K = 4,
  parameter int MAX_BEATS = 4,
  localparam int W_Y = W_X + W_K + $clog2(C) + $clog2(MAX_BEATS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  input  logic                 sgn,
  input  logic [R*C*W_K-1:0]   k,
  input  logic [C*W_X-1:0]     x,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [R*W_Y-1:0]     y,
  output logic                 ovf
);
  function automatic int cnt_at(input int i);
    int n;
    n = C;
    for (int j = 0; j < i; j++) n = (n + 1) / 2;
    return n;
  endfunction
  function automatic int off_at(input int i);
    int o;
    o = 0;
    for (int j = 0; j < i; j++) o += cnt_at(j) * W_Y;
    return o;
  endfunction
  // Operands gain one bit so unsigned and two's complement share one signed multiplier.
  function automatic logic [W_Y-1:0] prod(input logic [W_X-1:0] a, input logic [W_K-1:0] b, input logic s);
    logic signed [W_X:0] ae;
    logic signed [W_K:0] be;
    logic signed [W_X+W_K+1:0] p;
    ae = {s & a[W_X-1], a};
    be = {s & b[W_K-1], b};
    p = ae * be;
    return W_Y'(p);
  endfunction
  localparam int L = $clog2(C);
  localparam int CW = $clog2(MAX_BEATS + 2);
  localparam logic [CW-1:0] MB = CW'(MAX_BEATS);
  localparam int TOT = off_at(L + 1);
  localparam int OFF_L = off_at(L);
  logic adv;
  logic in_v_q, in_l_q, in_s_q;
  logic [R*C*W_K-1:0] k_q;
  logic [C*W_X-1:0] x_q;
  // Every tree level of a row lives in one packed vector; level i starts at off_at(i).
  logic [TOT-1:0] t_q [R];
  logic [TOT-1:0] t_d [R];
  logic [L:0] v_q, v_d, l_q, l_d;
  logic [R*W_Y-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic first_q, first_d, mv_q, mv_d, ovf_q, ovf_d;
  assign adv = !mv_q || m_ready;
  assign s_ready = adv;
  assign m_valid = mv_q;
  assign y = acc_q;
  assign ovf = ovf_q;
  always_comb begin
    for (int r = 0; r < R; r++) begin
      t_d[r] = '0;
      for (int c = 0; c < C; c++)
        t_d[r][c*W_Y +: W_Y] = prod(x_q[c*W_X +: W_X], k_q[(r*C+c)*W_K +: W_K], in_s_q);
      for (int i = 1; i <= L; i++)
        for (int j = 0; j < cnt_at(i); j++)
          if (2*j + 1 < cnt_at(i-1))
            t_d[r][off_at(i) + j*W_Y +: W_Y] = t_q[r][off_at(i-1) + 2*j*W_Y +: W_Y] + t_q[r][off_at(i-1) + (2*j+1)*W_Y +: W_Y];
          else
            t_d[r][off_at(i) + j*W_Y +: W_Y] = t_q[r][off_at(i-1) + 2*j*W_Y +: W_Y];
    end
  end
  always_comb begin
    v_d[0] = in_v_q;
    l_d[0] = in_l_q;
    for (int i = 1; i <= L; i++) begin
      v_d[i] = v_q[i-1];
      l_d[i] = l_q[i-1];
    end
  end
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    first_d = first_q;
    mv_d = mv_q;
    ovf_d = ovf_q;
    if (adv) begin
      mv_d = 1'b0;
      if (v_q[L]) begin
        for (int r = 0; r < R; r++)
          acc_d[r*W_Y +: W_Y] = first_q ? t_q[r][OFF_L +: W_Y] : acc_q[r*W_Y +: W_Y] + t_q[r][OFF_L +: W_Y];
        cnt_d = first_q ? CW'(1) : (cnt_q > MB ? cnt_q : cnt_q + 1'b1);
        ovf_d = cnt_d > MB;
        first_d = l_q[L];
        mv_d = l_q[L];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      in_v_q <= 1'b0;
      in_l_q <= 1'b0;
      in_s_q <= 1'b0;
      k_q <= '0;
      x_q <= '0;
      for (int r = 0; r < R; r++) t_q[r] <= '0;
      v_q <= '0;
      l_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      first_q <= 1'b1;
      mv_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (adv) begin
        in_v_q <= s_valid;
        in_l_q <= s_last;
        in_s_q <= sgn;
        k_q <= k;
        x_q <= x;
        for (int r = 0; r < R; r++) t_q[r] <= t_d[r];
        v_q <= v_d;
        l_q <= l_d;
      end
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      first_q <= first_d;
      mv_q <= mv_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_matvec_mul_stream.sv
// tb_matvec_mul_stream: directed and randomized checks of matvec_mul_stream against a dot-product reference.
module tb_matvec_mul_stream;
  localparam int R = 2;
  localparam int C = 5;
  localparam int W_X = 3;
  localparam int W_K = 4;
  localparam int MAX_BEATS = 4;
  localparam int W_Y = W_X + W_K + $clog2(C) + $clog2(MAX_BEATS);
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, s_last = 1'b0, sgn = 1'b0, m_ready;
  logic s_ready, m_valid, ovf;
  logic [R*C*W_K-1:0] k = '0;
  logic [C*W_X-1:0] x = '0;
  logic [R*W_Y-1:0] y;
  logic mr_rand = 1'b0, mr_fix = 1'b1;
  int checks = 0, errors = 0, n_out = 0;
  int macc [R];
  int mcnt = 0;
  logic mfirst = 1'b1;
  logic [R*W_Y:0] exp_q [$];

  matvec_mul_stream dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .sgn(sgn),
    .k(k), .x(x), .m_valid(m_valid), .m_ready(m_ready), .y(y), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      m_ready = mr_rand ? ($urandom_range(0, 3) != 0) : mr_fix;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int sx(input int v, input int w, input logic s);
    return (s && v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  function automatic int dot(input int r, input logic [C*W_X-1:0] xv, input logic [R*C*W_K-1:0] kv, input logic s);
    int sum;
    sum = 0;
    for (int c = 0; c < C; c++)
      sum += sx(int'(xv[c*W_X +: W_X]), W_X, s) * sx(int'(kv[(r*C+c)*W_K +: W_K]), W_K, s);
    return sum;
  endfunction

  function automatic logic [R*C*W_K-1:0] kf(input logic [W_K-1:0] a, input logic [W_K-1:0] b);
    logic [R*C*W_K-1:0] kv;
    for (int c = 0; c < C; c++) begin
      kv[c*W_K +: W_K] = a;
      kv[(C+c)*W_K +: W_K] = b;
    end
    return kv;
  endfunction

  function automatic logic [C*W_X-1:0] xf(input logic [W_X-1:0] v);
    logic [C*W_X-1:0] xv;
    for (int c = 0; c < C; c++) xv[c*W_X +: W_X] = v;
    return xv;
  endfunction

  function automatic logic [R*W_Y-1:0] yy(input logic [W_Y-1:0] a, input logic [W_Y-1:0] b);
    return {b, a};
  endfunction

  // Reference: whole-packet dot products in plain integers, results queued in delivery order.
  always @(negedge clk) begin
    logic [R*W_Y:0] e;
    if (rst) begin
      mfirst = 1'b1;
      mcnt = 0;
      exp_q.delete();
    end else begin
      if (m_valid) begin
        if (exp_q.size() == 0) check("spurious_m_valid", m_valid, 0);
        else begin
          check("model_y", y, exp_q[0][R*W_Y-1:0]);
          check("model_ovf", ovf, exp_q[0][R*W_Y]);
          if (m_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (s_valid && s_ready) begin
        for (int r = 0; r < R; r++) macc[r] = (mfirst ? 0 : macc[r]) + dot(r, x, k, sgn);
        mcnt = mfirst ? 1 : mcnt + 1;
        mfirst = s_last;
        if (s_last) begin
          for (int r = 0; r < R; r++) e[r*W_Y +: W_Y] = macc[r][W_Y-1:0];
          e[R*W_Y] = mcnt > MAX_BEATS;
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [C*W_X-1:0] xv, input logic [R*C*W_K-1:0] kv, input logic s, input logic last);
    int t;
    t = 0;
    s_valid = 1'b1;
    x = xv;
    k = kv;
    sgn = s;
    s_last = last;
    do begin
      @(negedge clk);
      t++;
    end while (!s_ready && t < 200);
    if (!s_ready) check("s_ready_timeout", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_res(input string nm, input logic [R*W_Y-1:0] ey, input logic eo, input int elat);
    int lat;
    lat = 0;
    while (!m_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({nm, "_valid"}, m_valid, 1);
    check({nm, "_y"}, y, ey);
    check({nm, "_ovf"}, ovf, eo);
    if (elat >= 0) check({nm, "_latency"}, lat, elat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int o, t, len;
    logic s;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_s_ready", s_ready, 1);
    check("reset_m_valid", m_valid, 0);
    check("reset_y", y, 0);
    check("reset_ovf", ovf, 0);
    send(xf(1), kf(1, 4'hF), 1'b1, 1'b1);
    wait_res("t1_signed", yy(5, 12'hFFB), 1'b0, 5);
    send(xf(1), kf(1, 4'hF), 1'b0, 1'b1);
    wait_res("t2_unsigned", yy(5, 75), 1'b0, 5);
    send(xf(3'b100), kf(4'b1000, 4'b1000), 1'b1, 1'b1);
    wait_res("t2_extreme", yy(160, 160), 1'b0, 5);
    o = n_out;
    send(xf(3), kf(2, 2), 1'b1, 1'b0);
    send(xf(3'b100), kf(7, 7), 1'b1, 1'b1);
    wait_res("t3_two_beat", yy(12'hF92, 12'hF92), 1'b0, 5);
    repeat (10) @(posedge clk);
    #1;
    check("t3_pulses", n_out - o, 1);
    mr_fix = 1'b0;
    o = n_out;
    send(xf(1), kf(1, 0), 1'b0, 1'b1);
    send(xf(1), kf(2, 0), 1'b0, 1'b1);
    send(xf(1), kf(3, 0), 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("t4_m_valid", m_valid, 1);
    check("t4_s_ready", s_ready, 0);
    check("t4_hold_y", y, yy(5, 0));
    mr_fix = 1'b1;
    t = 0;
    while (n_out - o < 3 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("t4_count", n_out - o, 3);
    check("t4_queue_empty", exp_q.size(), 0);
    for (int i = 0; i < 5; i++) send(xf(1), kf(1, 1), 1'b0, i == 4);
    wait_res("t5_overflow", yy(25, 25), 1'b1, 5);
    send(xf(1), kf(1, 1), 1'b0, 1'b1);
    wait_res("t5_after", yy(5, 5), 1'b0, 5);
    o = n_out;
    send(xf(1), kf(1, 1), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_output", n_out - o, 0);
    check("t6_m_valid_low", m_valid, 0);
    send(xf(1), kf(2, 2), 1'b0, 1'b1);
    wait_res("t6_fresh", yy(10, 10), 1'b0, 5);
    mr_rand = 1'b1;
    o = n_out;
    for (int p = 0; p < 1000; p++) begin
      len = $urandom_range(1, 6);
      s = 1'($urandom_range(0, 1));
      for (int b = 0; b < len; b++) begin
        while ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        send((C*W_X)'($urandom), (R*C*W_K)'({$urandom, $urandom}), s, b == len - 1);
      end
    end
    mr_rand = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("rand_drain", exp_q.size(), 0);
    check("rand_outputs", n_out - o, 1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/matvec_mul_stream.md
Name: matvec_mul_stream

Overview:
- Streaming, fully pipelined signed/unsigned matrix-vector multiplier with valid/ready handshakes on input and output.
- Computes y[r] = sum over c of k[r][c]*x[c] for an R x C tile each beat.
- Accumulates across a packet of beats (column tiles), closed by s_last, so matrices wider than C are handled by tiling.
- Sits between the operand fetch buffers and the result writeback FIFO; successor to matvec_mul, adding flow control, tiling, a runtime sign mode and overflow flagging.

Parameters:
R, 2, matrix rows / output lanes
C, 5, columns per beat (adder-tree width)
W_X, 3, x element width
W_K, 4, k element width
MAX_BEATS, 4, beats per packet guaranteed overflow-free (power of two, >=1)
W_Y, W_X+W_K+$clog2(C)+$clog2(MAX_BEATS), output element width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
s_valid  in  1  input beat valid
s_ready  out  1  block can accept a beat
s_last  in  1  final beat of packet
sgn  in  1  1: operands of this beat are two's complement; 0: unsigned
k  in  R*C*W_K  packed k[R][C], element [r][c] at bits ((r*C+c)*W_K)+:W_K
x  in  C*W_X  packed x[C]
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
y  out  R*W_Y  packed y[R], signed when the packet's last beat had sgn=1, else unsigned
ovf  out  1  packet exceeded MAX_BEATS beats (qualified by m_valid)

Behaviour:
- Reset: rst sampled on the clk edge. Clears all pipeline valid bits, accumulator, beat counter, y=0, m_valid=0, ovf=0. s_ready=1 from the first cycle after reset.
- Reset mid-packet discards every in-flight beat and partial sum. No result is emitted for it.
- Handshake: a beat transfers when s_valid&&s_ready; a result transfers when m_valid&&m_ready.
- Once m_valid is asserted, y, ovf and m_valid stay stable until the transfer.
- Stall: adv = !m_valid || m_ready. The whole pipeline advances only when adv=1. s_ready = adv (combinational, no skid buffer).
- Pipeline stages, each registered and each carrying valid, last and sgn:
  - Stage 1: R*C products, each operand extended by one bit (sign- or zero-extension per sgn).
  - Stages 2..$clog2(C)+1: binary adder tree. With odd counts, the unpaired term passes through.
  - Final stage: accumulator/output register.
- Latency: a last beat accepted on edge n produces m_valid=1 after edge n+$clog2(C)+2 when unstalled. Default is 5 cycles.
- Throughput: one beat per cycle with m_ready=1.
- Accumulator, when a valid tree result arrives and adv=1:
  - If it is the first beat of a packet: acc = sum, else acc = acc + sum, all arithmetic modulo 2^W_Y.
  - If that beat has last set: m_valid <= 1, y <= the new acc, and the next arriving beat starts a new packet.
  - A result leaving via m_ready in the same cycle that a new first beat arrives is legal. The new beat loads fresh with no bubble.
- Beat counter: counts beats per packet, saturating at MAX_BEATS+1. ovf = 1 when the count exceeds MAX_BEATS; y is then the modulo-wrapped sum. Cleared at the start of each packet.
- sgn must be constant within a packet. Mixed sgn within a packet is undefined and is not checked.
- When not stalled, idle cycles (s_valid=0) insert bubbles and do not disturb the partial accumulator.

Test Plan:
1. Default params, sgn=1, x[c]=1, k row0 all 1, row1 all 4'hF, single beat with s_last=1 → 5 cycles later m_valid=1, y[0]=5, y[1]=-5, ovf=0.
2. Same operands with sgn=0 → y[0]=5, y[1]=75. Extremes with sgn=1, x=3'b100, k=4'b1000 on all elements → y[0]=y[1]=160.
3. Two-beat packet, sgn=1:
   - beat A: x=3, k=2 (30 per row);
   - beat B: x=-4, k=7 (-140 per row), s_last=1;
   - → single result y[0]=y[1]=-110, one m_valid pulse.
4. Backpressure: three back-to-back single-beat packets (expected y0 = 5, 10, 15), m_ready=0 for 10 cycles → s_ready falls, first result held stable. Releasing m_ready delivers 5, 10, 15 in order, with none lost or duplicated.
5. Five-beat packet with x=1, k=1 each beat → y=25 with ovf=1. A following single-beat packet returns ovf=0.
6. Assert rst for 1 cycle after beat 1 of a 2-beat packet → no m_valid; the next 1-beat packet yields only its own sum. Random 1000-packet comparison against a reference model, with random m_ready and s_valid.
